dot_mac_pipe: RTL

Parametrised, pipelined unsigned dot-product / multiply-accumulate engine: each accepted beat multiplies LANES operand pairs, reduces them through a registered adder tree, and optionally adds the sum into a running accumulator. It is the generalised successor of the team's fixed two-pair multiply-add pipeline. It adds configurable widths and lane count, a valid/ready handshake with backpressure, an accumulate mode and synchronous reset. It sits between an operand source (register file / memory streamer) and any result consumer.

---
 rtl/dot_mac_pkg.sv | 23 ++
 rtl/dot_add_level.sv | 44 ++++
 rtl/dot_mac_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/dot_mac_pkg.sv
// Shared constants and helpers for the dot-product / multiply-accumulate pipe.
package dot_mac_pkg;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

   localparam int DEF_WIDTH = 32;
   localparam int DEF_LANES = 4;
   localparam int DEF_ACC_W = 64;

   localparam int PROD_W = 2 * DEF_WIDTH;
   localparam int SUM_W  = PROD_W + clog2(DEF_LANES);

endpackage

// File: rtl/dot_add_level.sv
// One registered level of the reduction tree: adds adjacent input pairs,
// each sum one bit wider than its operands; holds everything while hold is high.
module dot_add_level
   import dot_mac_pkg::*;
#(
   parameter int N    = 4,
   parameter int IN_W = 64
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         hold,
   input  logic                         in_valid,
   input  logic                         in_acc,
   input  logic [N*IN_W-1:0]            in_data,
   output logic                         out_valid,
   output logic                         out_acc,
   output logic [(N/2)*(IN_W+1)-1:0]    out_data
);

   localparam int OUT_W = IN_W + 1;

   logic [(N/2)*OUT_W-1:0] sums;

   always_comb begin
      sums = '0;
      for (int i = 0; i < N / 2; i++) begin
         sums[i*OUT_W +: OUT_W] = OUT_W'(in_data[(2*i)*IN_W +: IN_W])
                                + OUT_W'(in_data[(2*i+1)*IN_W +: IN_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_acc   <= 1'b0;
         out_data  <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         out_acc   <= in_acc;
         out_data  <= sums;
      end
   end

endmodule

// File: rtl/dot_mac_pipe.sv
// Pipelined unsigned dot-product / multiply-accumulate engine with a
// valid/ready handshake; a single global stall freezes every stage.
module dot_mac_pipe
   import dot_mac_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LANES = DEF_LANES,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic                   in_acc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_data
);

   localparam int LVLS = clog2(LANES);
   localparam int PW   = 2 * WIDTH;
   localparam int SW   = PW + LVLS;

   // Bit offset of tree level lvl inside the flat tree bus (level 0 = products).
   function automatic int lvl_off(input int lvl);
      int off;
      off = 0;
      for (int j = 0; j < lvl; j++) begin
         off += (LANES >> j) * (PW + j);
      end
      return off;
   endfunction

   localparam int TREE_W = lvl_off(LVLS) + SW;

   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   logic                  m_valid;
   logic                  m_acc;
   logic [LANES*PW-1:0]   m_prod;
   logic [LANES*PW-1:0]   prod_next;

   always_comb begin
      prod_next = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_next[i*PW +: PW] = PW'(in_a[i*WIDTH +: WIDTH]) * PW'(in_b[i*WIDTH +: WIDTH]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid <= 1'b0;
         m_acc   <= 1'b0;
         m_prod  <= '0;
      end else if (!stall) begin
         m_valid <= in_valid;
         m_acc   <= in_acc;
         m_prod  <= prod_next;
      end
   end

   logic [TREE_W-1:0] tree;
   logic [LVLS:0]     tree_valid;
   logic [LVLS:0]     tree_acc;

   assign tree[LANES*PW-1:0] = m_prod;
   assign tree_valid[0]      = m_valid;
   assign tree_acc[0]        = m_acc;

   for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      dot_add_level #(
         .N    (LANES >> l),
         .IN_W (PW + l)
      ) u_add (
         .clk       (clk),
         .reset     (reset),
         .hold      (stall),
         .in_valid  (tree_valid[l]),
         .in_acc    (tree_acc[l]),
         .in_data   (tree[lvl_off(l) +: (LANES >> l) * (PW + l)]),
         .out_valid (tree_valid[l+1]),
         .out_acc   (tree_acc[l+1]),
         .out_data  (tree[lvl_off(l+1) +: (LANES >> (l+1)) * (PW + l + 1)])
      );
   end

   logic [SW-1:0]    s_sum;
   logic [ACC_W-1:0] sum_ext;
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_next;

   assign s_sum    = tree[lvl_off(LVLS) +: SW];
   assign sum_ext  = ACC_W'(s_sum);
   assign acc_next = tree_acc[LVLS] ? acc_q + sum_ext : sum_ext;

   // Accumulator only moves here, in beat order, so back-to-back accumulates need no bypass.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_valid <= tree_valid[LVLS];
         if (tree_valid[LVLS]) begin
            acc_q    <= acc_next;
            out_data <= acc_next;
         end
      end
   end

endmodule
